// File: rtl/exam_alu_pkg.sv
// Shared types and constants for the exam system sequential ALU.
// Holds the opcode encoding seen on the op port, the control FSM states
// and the mode encoding used by the shared multiply/divide shift core.
package exam_alu_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MULU = 2'b10,
      OP_DIVU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/exam_shift_core.sv
// Iterative shift datapath shared by unsigned multiply and unsigned
// restoring divide. One algorithm step is performed per 'step' cycle on a
// 2*WIDTH accumulator {hi, lo}; after WIDTH steps it holds the result.
//
// Ports:
//   clk, rst_in  clock and synchronous active-high reset
//   start        load operands and arm the counter with WIDTH steps
//   mode         MODE_MUL or MODE_DIV, captured on start
//   step         perform one step (ignored when the counter is zero)
//   a, b         operands, sampled on start
//   done         high while the step in progress is the final one
//   lo, hi       accumulator halves: product low/high or quotient/remainder
module exam_shift_core
   import exam_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             start,
   input  logic             mode,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_cand;
   logic [WIDTH-1:0] rem_diff;

   // Next-state for the accumulator. On start the high half is cleared so no
   // stale data leaks into the result. Multiply keeps the multiplier in lo
   // and shifts right, adding the multiplicand into hi when the bit leaving
   // lo is set. Divide keeps the dividend in lo and shifts left into hi,
   // subtracting the divisor whenever the partial remainder allows it; the
   // quotient bits fill lo from the bottom as the dividend shifts out.
   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      opd_d    = opd_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      mul_sum  = '0;
      rem_cand = '0;
      rem_diff = '0;

      if (start) begin
         mode_d = mode;
         cnt_d  = CNT_W'(WIDTH);
         hi_d   = '0;
         if (mode == MODE_MUL) begin
            lo_d  = b;
            opd_d = a;
         end else begin
            lo_d  = a;
            opd_d = b;
         end
      end else if (step && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (mode_q == MODE_MUL) begin
            mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
            hi_d    = mul_sum[WIDTH:1];
            lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
         end else begin
            rem_cand = {hi_q, lo_q[WIDTH-1]};
            rem_diff = WIDTH'(rem_cand - {1'b0, opd_q});
            if (rem_cand >= {1'b0, opd_q}) begin
               hi_d = rem_diff;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = rem_cand[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // Accumulator, operand and counter registers. Reset clears the result
   // halves so an aborted operation leaves nothing visible behind.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opd_q  <= '0;
         cnt_q  <= '0;
         mode_q <= MODE_MUL;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opd_q  <= opd_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
      end
   end

   assign done = (cnt_q == CNT_W'(1));
   assign lo   = lo_q;
   assign hi   = hi_q;

endmodule

// File: rtl/exam_seq_alu.sv
// Handshaked arithmetic unit for the exam system. Accepts one operation at
// a time over valid/ready, computes add/sub in a single cycle and unsigned
// multiply/divide in WIDTH cycles through exam_shift_core, then holds the
// result until the consumer takes it.
//
// Ports:
//   clk, rst_in           clock and synchronous active-high reset
//   in_valid, in_ready    operation handshake (op, a, b captured on accept)
//   op                    00 add, 01 sub, 10 mulu, 11 divu
//   a, b                  operands
//   out_valid, out_ready  result handshake
//   r, r_hi               result low / high (product high or remainder)
//   flag_z/c/v, err       zero, carry/borrow, overflow, divide by zero
module exam_seq_alu
   import exam_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] r_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             err
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] r_hi_q, r_hi_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_c_q, flag_c_d;
   logic             flag_v_q, flag_v_d;
   logic             err_q, err_d;
   logic             core_sel_q, core_sel_d;
   logic             mul_sel_q, mul_sel_d;

   op_e              op_in;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_ext;

   logic             core_start;
   logic             core_mode;
   logic             core_step;
   logic             core_done;
   logic [WIDTH-1:0] core_lo;
   logic [WIDTH-1:0] core_hi;

   assign op_in     = op_e'(op);
   assign in_ready  = (state_q == S_IDLE) && !rst_in;
   assign out_valid = (state_q == S_DONE);
   assign accept    = in_valid && in_ready;

   // Add and subtract share one adder: subtract is a + ~b + 1. Because
   // b_eff already carries the inverted subtrahend, the same sign test
   // detects overflow for both operations.
   always_comb begin
      b_eff   = (op_in == OP_SUB) ? ~b : b;
      sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_in == OP_SUB)};
   end

   // Control FSM and result capture. Add/sub and divide-by-zero finish on
   // the accept edge; multiply and divide hand off to the shift core and
   // wait for its final step. core_sel records that the visible result
   // lives in the core accumulator rather than in the local registers.
   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      r_hi_d     = r_hi_q;
      flag_z_d   = flag_z_q;
      flag_c_d   = flag_c_q;
      flag_v_d   = flag_v_q;
      err_d      = err_q;
      core_sel_d = core_sel_q;
      mul_sel_d  = mul_sel_q;
      core_start = 1'b0;
      core_mode  = MODE_MUL;
      core_step  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op_in)
                  OP_ADD, OP_SUB: begin
                     r_d        = sum_ext[WIDTH-1:0];
                     r_hi_d     = '0;
                     flag_z_d   = (sum_ext[WIDTH-1:0] == '0);
                     flag_c_d   = (op_in == OP_SUB) ? !sum_ext[WIDTH] : sum_ext[WIDTH];
                     flag_v_d   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                  (sum_ext[WIDTH-1] != a[WIDTH-1]);
                     err_d      = 1'b0;
                     core_sel_d = 1'b0;
                     state_d    = S_DONE;
                  end
                  OP_MULU: begin
                     core_start = 1'b1;
                     core_mode  = MODE_MUL;
                     core_sel_d = 1'b1;
                     mul_sel_d  = 1'b1;
                     state_d    = S_BUSY;
                  end
                  OP_DIVU: begin
                     if (b == '0) begin
                        r_d        = '1;
                        r_hi_d     = a;
                        flag_z_d   = 1'b0;
                        flag_c_d   = 1'b0;
                        flag_v_d   = 1'b0;
                        err_d      = 1'b1;
                        core_sel_d = 1'b0;
                        state_d    = S_DONE;
                     end else begin
                        core_start = 1'b1;
                        core_mode  = MODE_DIV;
                        core_sel_d = 1'b1;
                        mul_sel_d  = 1'b0;
                        state_d    = S_BUSY;
                     end
                  end
               endcase
            end
         end
         S_BUSY: begin
            core_step = 1'b1;
            if (core_done) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset drops any operation in flight.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         r_q        <= '0;
         r_hi_q     <= '0;
         flag_z_q   <= 1'b0;
         flag_c_q   <= 1'b0;
         flag_v_q   <= 1'b0;
         err_q      <= 1'b0;
         core_sel_q <= 1'b0;
         mul_sel_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         r_hi_q     <= r_hi_d;
         flag_z_q   <= flag_z_d;
         flag_c_q   <= flag_c_d;
         flag_v_q   <= flag_v_d;
         err_q      <= err_d;
         core_sel_q <= core_sel_d;
         mul_sel_q  <= mul_sel_d;
      end
   end

   exam_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst_in (rst_in),
      .start  (core_start),
      .mode   (core_mode),
      .step   (core_step),
      .a      (a),
      .b      (b),
      .done   (core_done),
      .lo     (core_lo),
      .hi     (core_hi)
   );

   // Multiply/divide results are read straight from the core accumulator,
   // which stays frozen once the final step is taken, so flags derived from
   // it are valid in the same cycle out_valid rises.
   always_comb begin
      if (core_sel_q) begin
         r      = core_lo;
         r_hi   = core_hi;
         flag_z = (core_lo == '0);
         flag_c = 1'b0;
         flag_v = mul_sel_q && (core_hi != '0);
         err    = 1'b0;
      end else begin
         r      = r_q;
         r_hi   = r_hi_q;
         flag_z = flag_z_q;
         flag_c = flag_c_q;
         flag_v = flag_v_q;
         err    = err_q;
      end
   end

endmodule

// File: tb/tb_exam_seq_alu.sv
// Self-checking bench for exam_seq_alu at WIDTH=32. The driver pushes the
// reference model's expected result into a scoreboard queue on every
// accepted operation; an independent monitor pops and compares whenever a
// result is handed over, and also checks latency and in_ready behaviour.
module tb_exam_seq_alu;
   import exam_alu_pkg::*;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic         clk = 1'b0;
   logic         rst_in = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] r;
   logic [W-1:0] r_hi;
   logic         flag_z;
   logic         flag_c;
   logic         flag_v;
   logic         err;

   typedef struct {
      logic [W-1:0] r;
      logic [W-1:0] rHi;
      logic         z;
      logic         c;
      logic         v;
      logic         err;
      int           lat;
      int           acceptCycle;
   } expT;

   expT sb[$];
   int  vectors = 0;
   int  miscompares = 0;
   int  cycleCount = 0;
   bit  seenValid = 0;
   bit  readyCheck = 0;

   exam_seq_alu #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_in    (rst_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .r_hi      (r_hi),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .err       (err)
   );

   // Free-running clock and a cycle counter used to measure latency.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   // Reference model: plain integer arithmetic on wide types, with overflow
   // judged by whether the true signed result fits in 32 bits.
   function automatic expT model(input logic [1:0] opIn, input logic [W-1:0] aIn,
                                 input logic [W-1:0] bIn);
      expT           e;
      longint        sa;
      longint        sb2;
      longint        sres;
      logic [2*W-1:0] prod;
      sa  = longint'($signed(aIn));
      sb2 = longint'($signed(bIn));
      e.r = '0;
      e.rHi = '0;
      e.c = 1'b0;
      e.v = 1'b0;
      e.err = 1'b0;
      e.lat = 1;
      e.acceptCycle = 0;
      case (opIn)
         2'b00: begin
            e.r  = aIn + bIn;
            e.c  = ({32'd0, aIn} + {32'd0, bIn}) > 64'hFFFF_FFFF;
            sres = sa + sb2;
            e.v  = (sres > SMAX) || (sres < SMIN);
         end
         2'b01: begin
            e.r  = aIn - bIn;
            e.c  = aIn < bIn;
            sres = sa - sb2;
            e.v  = (sres > SMAX) || (sres < SMIN);
         end
         2'b10: begin
            prod  = {32'd0, aIn} * {32'd0, bIn};
            e.r   = prod[W-1:0];
            e.rHi = prod[2*W-1:W];
            e.v   = (e.rHi != 0);
            e.lat = W + 1;
         end
         default: begin
            if (bIn == 0) begin
               e.r   = '1;
               e.rHi = aIn;
               e.err = 1'b1;
            end else begin
               e.r   = aIn / bIn;
               e.rHi = aIn % bIn;
               e.lat = W + 1;
            end
         end
      endcase
      e.z = (e.r == 0);
      return e;
   endfunction

   // Single comparison point: every check goes through here.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                  name, actual, expected, cycleCount);
      end
   endtask

   // Wait (bounded) for in_ready, present one operation, and on the accept
   // edge record the model's expectation. Inputs are scrambled afterwards to
   // show the DUT captured them at accept.
   task automatic applyStimulus(input logic [1:0] opIn, input logic [W-1:0] aIn,
                                input logic [W-1:0] bIn);
      int  waitCycles;
      expT e;
      waitCycles = 0;
      @(negedge clk);
      while (!in_ready && waitCycles < 400) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
         return;
      end
      op       = opIn;
      a        = aIn;
      b        = bIn;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e = model(opIn, aIn, bIn);
      e.acceptCycle = cycleCount;
      sb.push_back(e);
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
   endtask

   // Bounded wait for all outstanding results to be consumed.
   task automatic waitDrain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compares each handed-over result against the scoreboard head,
   // checks the latency from accept to first out_valid, that in_ready stays
   // low while an operation is outstanding, and that it returns right after
   // a result is taken.
   always @(negedge clk) begin
      expT e;
      if (readyCheck) begin
         checkOutput("in_ready_after_take", 64'(in_ready), 64'd1);
         readyCheck = 0;
      end
      if (sb.size() > 0) begin
         checkOutput("in_ready_while_busy", 64'(in_ready), 64'd0);
      end
      if (out_valid) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_out_valid", 64'(out_valid), 64'd0);
         end else begin
            if (!seenValid) begin
               seenValid = 1;
               checkOutput("latency", 64'(cycleCount - sb[0].acceptCycle + 1),
                           64'(sb[0].lat));
            end
            if (out_ready) begin
               e = sb.pop_front();
               checkOutput("r", 64'(r), 64'(e.r));
               checkOutput("r_hi", 64'(r_hi), 64'(e.rHi));
               checkOutput("flag_z", 64'(flag_z), 64'(e.z));
               checkOutput("flag_c", 64'(flag_c), 64'(e.c));
               checkOutput("flag_v", 64'(flag_v), 64'(e.v));
               checkOutput("err", 64'(err), 64'(e.err));
               seenValid  = 0;
               readyCheck = 1;
            end
         end
      end
   end

   // Main sequence: reset, directed cases, backpressure, abort by reset,
   // then a randomized run biased towards corner operands.
   initial begin
      logic [1:0]   opR;
      logic [W-1:0] aR;
      logic [W-1:0] bR;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_r", 64'(r), 64'd0);
      checkOutput("reset_r_hi", 64'(r_hi), 64'd0);
      checkOutput("reset_flags", 64'({flag_z, flag_c, flag_v, err}), 64'd0);
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'h1);
      applyStimulus(2'b01, 32'd5, 32'd7);
      applyStimulus(2'b01, 32'h8000_0000, 32'h1);
      applyStimulus(2'b10, 32'h0001_0000, 32'h0001_0000);
      applyStimulus(2'b11, 32'd100, 32'd7);
      applyStimulus(2'b11, 32'd9, 32'd0);
      waitDrain();

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(2'b00, 32'd3, 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_r", 64'(r), 64'd7);
         if (i == 1) begin
            op       = 2'b00;
            a        = 32'd1;
            b        = 32'd1;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(2'b00, 32'd1, 32'd1);
      waitDrain();

      $display("[TB] reset during multiply");
      @(negedge clk);
      op       = 2'b10;
      a        = 32'h0000_1234;
      b        = 32'h0000_5678;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_in = 1'b1;
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      @(negedge clk);
      checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort_r", 64'(r), 64'd0);
      checkOutput("abort_r_hi", 64'(r_hi), 64'd0);
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      repeat (40) @(negedge clk);
      checkOutput("abort_no_result", 64'(out_valid), 64'd0);

      $display("[TB] random operations");
      for (int i = 0; i < 40; i++) begin
         opR = 2'($urandom_range(0, 3));
         aR  = pickOperand();
         bR  = pickOperand();
         if ($urandom_range(0, 7) == 0) begin
            bR = '0;
         end
         applyStimulus(opR, aR, bR);
      end
      waitDrain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/exam_seq_alu.md
Name: exam_seq_alu

Overview:
- Parametrised arithmetic unit for the exam system, replacing fixed 32-bit a/b -> r exports with a handshaked operand/result path.
- Accepts two WIDTH-bit operands and an opcode via valid/ready.
- Computes add/sub in one cycle; unsigned multiply and divide take WIDTH cycles using an iterative shift core.
- Sits between the PIO/bus front end and the result register. Holds one operation at a time.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk        input   1        system clock, all logic on rising edge
rst_in     input   1        synchronous, active-high reset
in_valid   input   1        operand/opcode valid
in_ready   output  1        unit can accept an operation
op         input   2        00 add, 01 sub, 10 mulu, 11 divu
a          input   WIDTH    operand A (dividend / minuend)
b          input   WIDTH    operand B (divisor / subtrahend)
out_valid  output  1        result valid, held until out_ready
out_ready  input   1        consumer accepts result
r          output  WIDTH    sum/diff, product low half, quotient
r_hi       output  WIDTH    product high half, remainder; 0 for add/sub
flag_z     output  1        r == 0
flag_c     output  1        add carry-out / sub borrow; 0 for mul/div
flag_v     output  1        add/sub signed overflow; mul: r_hi != 0; div: 0
err        output  1        divide by zero

Behaviour:
- Reset (rst_in high at a clock edge): state goes to IDLE. r, r_hi, all flags, err and out_valid are 0. in_ready is forced 0 while rst_in is high. Reset aborts any operation in progress with no partial result.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE) && !rst_in.
  - out_valid = (state == DONE).
- Accept: occurs on the edge where in_valid && in_ready (call this cycle 0). a, b and op are captured at that edge; later input changes are ignored.
- Add/sub: result is registered at cycle 0 and the FSM goes IDLE->DONE. out_valid is high from cycle 1.
  - Sub computes a + ~b + 1. flag_c = borrow = !carry_out.
  - Add overflow: a[W-1] == b[W-1] && r[W-1] != a[W-1].
  - Sub overflow: a[W-1] != b[W-1] && r[W-1] != a[W-1].
- Mulu: IDLE->BUSY with counter = WIDTH.
  - Each BUSY cycle does one shift-add step on a 2*WIDTH accumulator, then decrements the counter.
  - After WIDTH BUSY cycles the FSM goes to DONE, so out_valid is high from cycle WIDTH+1.
  - Output: {r_hi, r} = a*b.
- Divu: restoring division, same timing as mulu (WIDTH BUSY cycles, out_valid from cycle WIDTH+1). Output: r = a/b, r_hi = a%b.
- Divide by zero (op=11, b=0): no BUSY phase; IDLE->DONE with out_valid from cycle 1. Outputs: r = all ones, r_hi = a, err = 1.
  - err is 0 for every other result.
- DONE:
  - Outputs are stable while out_ready is low; any in_valid is ignored because in_ready = 0.
  - When out_ready is high: DONE->IDLE, out_valid drops next cycle, and in_ready rises that same cycle.
  - Back-to-back throughput is one operation per (latency + 1) cycles.
  - r, r_hi and flags keep their last values in IDLE. Only out_valid qualifies them.
- flag_z is computed from the final r for every op, including divide by zero (where it is 0).
- Width rule: all arithmetic is unsigned modulo 2^WIDTH except the flag_v definitions above. No X propagation: the unused accumulator half is zeroed on accept.

Decomposition:
- Package exam_alu_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_MULU, OP_DIVU)
  - state_e enum (S_IDLE, S_BUSY, S_DONE)
  - localparam OP_W = 2
- One sub-module, exam_shift_core: the iterative datapath holding the 2*WIDTH accumulator and counter, shared between mulu and divu.
  - Controls: start, mode, step.
  - Outputs: done, lo, hi.
- The top level owns the FSM, add/sub, flags and the handshake.

Test Plan (WIDTH=32):
1. Add a=0xFFFFFFFF, b=0x1, out_ready=1 -> out_valid at cycle 1; r=0, flag_z=1, flag_c=1, flag_v=0; in_ready back at cycle 2.
2. Sub a=5, b=7 -> r=0xFFFFFFFE, flag_c=1, flag_v=0. Then sub a=0x80000000, b=1 -> r=0x7FFFFFFF, flag_v=1.
3. Mulu a=0x00010000, b=0x00010000 -> out_valid at cycle 33; r=0, r_hi=1, flag_z=1, flag_v=1; in_ready=0 for cycles 1..33.
4. Divu a=100, b=7 -> cycle 33: r=14, r_hi=2, err=0. Divu a=9, b=0 -> cycle 1: r=0xFFFFFFFF, r_hi=9, err=1.
5. Backpressure: add a=3, b=4 with out_ready=0 for 5 cycles and in_valid pulsed with a=1, b=1 -> r stays 7, out_valid held, second op not accepted. Raise out_ready -> next accept yields r=2.
6. Reset mid-mulu: assert rst_in at cycle 10 for 1 cycle -> next cycle out_valid=0, r=0, r_hi=0, in_ready=1 once rst_in is low; no result emitted for the aborted op.
